// File: rtl/dr_scan_chain.sv
// JTAG data-register stage: BYPASS / IDCODE / USER selection with capture-shift-update.
// Optional shift-length checking on USER update is enabled by defining DR_LEN_CHECK_EN.
module dr_scan_chain #(
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
    parameter int          USER_W     = 16,
    parameter int          IR_W       = 4
) (
    input  logic              TCK,
    input  logic              rst,
    input  logic              TDI,
    input  logic [IR_W-1:0]   JTAG_IR,
    input  logic              CAPTUREDR,
    input  logic              SHIFTDR,
    input  logic              UPDATEDR,
    input  logic [USER_W-1:0] user_in,
    output logic              TDO,
    output logic              TDO_en,
    output logic [USER_W-1:0] user_out,
    output logic              user_upd,
    output logic              len_err
);

    typedef enum logic [1:0] {
        SEL_BYPASS,
        SEL_IDCODE,
        SEL_USER
    } dr_sel_e;

    dr_sel_e           dr_sel;
    logic              bypass_sr;
    logic [31:0]       idcode_sr;
    logic [USER_W-1:0] user_sr;
    logic              do_update;

    always_comb begin
        dr_sel = SEL_BYPASS;
        if (JTAG_IR == IR_W'(1))      dr_sel = SEL_IDCODE;
        else if (JTAG_IR == IR_W'(2)) dr_sel = SEL_USER;
    end

    // Strobe priority: capture beats shift beats update.
    assign do_update = UPDATEDR && !CAPTUREDR && !SHIFTDR && (dr_sel == SEL_USER);

    always_ff @(posedge TCK) begin
        if (rst) begin
            bypass_sr <= 1'b0;
            idcode_sr <= IDCODE_VAL;
            user_sr   <= '0;
        end else if (CAPTUREDR) begin
            case (dr_sel)
                SEL_IDCODE: idcode_sr <= IDCODE_VAL;
                SEL_USER:   user_sr   <= user_in;
                default:    bypass_sr <= 1'b0;
            endcase
        end else if (SHIFTDR) begin
            case (dr_sel)
                SEL_IDCODE: idcode_sr <= {TDI, idcode_sr[31:1]};
                SEL_USER:   user_sr   <= {TDI, user_sr[USER_W-1:1]};
                default:    bypass_sr <= TDI;
            endcase
        end
    end

`ifdef DR_LEN_CHECK_EN
    localparam int CNT_W = $clog2(2*USER_W + 1);

    logic [CNT_W-1:0] shift_cnt;
    logic             len_ok;
    logic             len_err_q;

    // Counter saturates so an over-long shift can never wrap back to a "good" length.
    always_ff @(posedge TCK) begin
        if (rst || CAPTUREDR) begin
            shift_cnt <= '0;
        end else if (SHIFTDR && (shift_cnt != CNT_W'(2*USER_W))) begin
            shift_cnt <= shift_cnt + 1'b1;
        end
    end

    assign len_ok = (shift_cnt == CNT_W'(USER_W));

    always_ff @(posedge TCK) begin
        if (rst) begin
            len_err_q <= 1'b0;
        end else if (do_update && !len_ok) begin
            len_err_q <= 1'b1;
        end
    end

    assign len_err = len_err_q;
`else
    logic len_ok;
    assign len_ok  = 1'b1;
    assign len_err = 1'b0;
`endif

    always_ff @(posedge TCK) begin
        if (rst) begin
            user_out <= '0;
            user_upd <= 1'b0;
        end else begin
            user_upd <= 1'b0;
            if (do_update && len_ok) begin
                user_out <= user_sr;
                user_upd <= 1'b1;
            end
        end
    end

    always_comb begin
        case (dr_sel)
            SEL_IDCODE: TDO = idcode_sr[0];
            SEL_USER:   TDO = user_sr[0];
            default:    TDO = bypass_sr;
        endcase
    end

    assign TDO_en = SHIFTDR;

endmodule
